// File: rtl/gait_step_sequencer_pkg.sv
// Shared definitions for the crabdle gait sequencer: bus widths, FSM encoding,
// board clock defaults and the ROM address stepping helper.
package gait_step_sequencer_pkg;

  localparam int unsigned POS_W       = 8;
  localparam int unsigned SPEED_W     = 4;
  localparam int unsigned CNT_W       = 9;
  localparam int unsigned DEF_CLK_HZ  = 12000000;
  localparam int unsigned DEF_STEP_HZ = 50;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Next ROM address with wrap at both ends of 0..last.
  function automatic logic [POS_W-1:0] step_addr(
    input logic [POS_W-1:0] pos,
    input logic             down,
    input logic [POS_W-1:0] last
  );
    if (down) begin
      step_addr = (pos == 8'd0) ? last : pos - 8'd1;
    end else begin
      step_addr = (pos == last) ? 8'd0 : pos + 8'd1;
    end
  endfunction

endpackage

// File: rtl/gait_step_sequencer_tick_gen.sv
// Servo-period prescaler: while run is high, pulses tick for one clock every DIV clocks.
// Held at zero when not running so the first tick always lands DIV clocks after run rises.
module gait_step_sequencer_tick_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rstn,
  input  logic run,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Prescaler counter, cleared whenever the sequencer is idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (!run) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = run && (cnt == LAST);

endmodule

// File: rtl/gait_step_sequencer.sv
// Gait step sequencer: walks the servo ROM address forward/backward at a programmable
// rate from a per-leg phase, looping or one-shot, and pulses cycle_done on each full sweep.
module gait_step_sequencer
  import gait_step_sequencer_pkg::*;
#(
  parameter int unsigned CLK_HZ   = DEF_CLK_HZ,
  parameter int unsigned STEP_HZ  = DEF_STEP_HZ,
  parameter int unsigned ROM_SIZE = 64,
  parameter int unsigned PHASE    = 0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_mode,
  input  logic               dir,
  input  logic [SPEED_W-1:0] speed,
  output logic [POS_W-1:0]   position,
  output logic               enable,
  output logic               busy,
  output logic               cycle_done
);

  localparam int unsigned DIV = CLK_HZ / STEP_HZ;
  localparam logic [POS_W-1:0] PHASE_ADDR = POS_W'(PHASE);
  localparam logic [POS_W-1:0] LAST_ADDR  = POS_W'(ROM_SIZE - 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(ROM_SIZE);

  if (ROM_SIZE < 2 || ROM_SIZE > 256) begin : g_bad_rom_size
    $error("gait_step_sequencer: ROM_SIZE must be 2..256");
  end
  if (PHASE >= ROM_SIZE) begin : g_bad_phase
    $error("gait_step_sequencer: PHASE must be below ROM_SIZE");
  end
  if (DIV < 2) begin : g_bad_div
    $error("gait_step_sequencer: CLK_HZ/STEP_HZ must be at least 2");
  end

  state_t             state;
  logic [SPEED_W-1:0] spd_cnt;
  logic [CNT_W-1:0]   step_cnt;
  logic               last_dir;
  logic               tick;
  logic [POS_W-1:0]   next_pos;
  logic [CNT_W-1:0]   next_cnt;
  logic               sweep_done;

  gait_step_sequencer_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rstn (rstn),
    .run  (state == ST_RUN),
    .tick (tick)
  );

  // Address and same-direction step count the next step would produce.
  always_comb begin
    next_pos   = step_addr(position, dir, LAST_ADDR);
    next_cnt   = '0;
    sweep_done = 1'b0;
    if (dir != last_dir) begin
      next_cnt = CNT_W'(1);
    end else begin
      next_cnt = step_cnt + CNT_W'(1);
    end
    // Once a full sweep's worth of steps is banked, the next arrival at PHASE completes it.
    if ((next_pos == PHASE_ADDR) && (next_cnt >= FULL_CNT)) begin
      sweep_done = 1'b1;
    end else begin
      sweep_done = 1'b0;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      position   <= PHASE_ADDR;
      enable     <= 1'b0;
      busy       <= 1'b0;
      cycle_done <= 1'b0;
      spd_cnt    <= '0;
      step_cnt   <= '0;
      last_dir   <= 1'b0;
    end else begin
      cycle_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            state    <= ST_RUN;
            position <= PHASE_ADDR;
            enable   <= 1'b1;
            busy     <= 1'b1;
            spd_cnt  <= '0;
            step_cnt <= '0;
            last_dir <= dir;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state  <= ST_IDLE;
            enable <= 1'b0;
            busy   <= 1'b0;
          end else if (tick) begin
            // >= so that lowering speed below the running count steps on the next tick.
            if (spd_cnt >= speed) begin
              spd_cnt  <= '0;
              position <= next_pos;
              last_dir <= dir;
              if (sweep_done) begin
                cycle_done <= 1'b1;
                step_cnt   <= '0;
                if (!loop_mode) begin
                  state  <= ST_IDLE;
                  enable <= 1'b0;
                  busy   <= 1'b0;
                end else begin
                  state <= ST_RUN;
                end
              end else begin
                step_cnt <= next_cnt;
              end
            end else begin
              spd_cnt <= spd_cnt + SPEED_W'(1);
            end
          end else begin
            state <= ST_RUN;
          end
        end
        default: begin
          state  <= ST_IDLE;
          enable <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
